// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the keypad column front end.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } deb_state_t;

   function automatic int CNT_W(input int deb_cycles);
      return $clog2(deb_cycles + 1);
   endfunction

   function automatic int SCAN_W(input int scan_div);
      return $clog2(scan_div);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One column's debounce FSM: commits a level change after DEBOUNCE_CYCLES
// consecutive mismatching samples and emits a one-cycle edge pulse.
module debounce_channel
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic s,
   input  logic se,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int CW = CNT_W(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);

   deb_state_t    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc = cnt + CW'(1);

   // Pulses default low every clk so they last one cycle even when se is sparse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (se) begin
            unique case (state)
               IDLE: begin
                  if (s) begin
                     if (DEBOUNCE_CYCLES == 1) begin
                        state  <= PRESSED;
                        cnt    <= '0;
                        stable <= 1'b1;
                        rise   <= 1'b1;
                     end else begin
                        state <= PRESS_WAIT;
                        cnt   <= CW'(1);
                     end
                  end
               end
               PRESS_WAIT: begin
                  if (!s) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (cnt_inc == DEB_C) begin
                     state  <= PRESSED;
                     cnt    <= '0;
                     stable <= 1'b1;
                     rise   <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               PRESSED: begin
                  if (!s) begin
                     if (DEBOUNCE_CYCLES == 1) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        stable <= 1'b0;
                        fall   <= 1'b1;
                     end else begin
                        state <= RELEASE_WAIT;
                        cnt   <= CW'(1);
                     end
                  end
               end
               RELEASE_WAIT: begin
                  if (s) begin
                     state <= PRESSED;
                     cnt   <= '0;
                  end else if (cnt_inc == DEB_C) begin
                     state  <= IDLE;
                     cnt    <= '0;
                     stable <= 1'b0;
                     fall   <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/keypad_col_debouncer.sv
// Column pin front end: polarity fix, synchroniser, per-channel debounce,
// and the free-running scan counter that paces the row scanner.
module keypad_col_debouncer
   import keypad_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DEB_ON_TICK     = 0,
   parameter int SCAN_DIV        = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WIDTH-1:0]              col,
   output logic [WIDTH-1:0]              col_stable,
   output logic [WIDTH-1:0]              press_pulse,
   output logic [WIDTH-1:0]              release_pulse,
   output logic                          any_pressed,
   output logic [SCAN_W(SCAN_DIV)-1:0]   counter,
   output logic                          scan_tick
);

   localparam int SW = SCAN_W(SCAN_DIV);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic             se;

   // Inverting ahead of the chain means everything downstream sees 1 = pressed.
   assign n = (ACTIVE_LOW != 0) ? ~col : col;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= n;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter <= '0;
      end else if (counter == SCAN_LAST) begin
         counter <= '0;
      end else begin
         counter <= counter + SW'(1);
      end
   end

   assign scan_tick   = (counter == SCAN_LAST);
   assign se          = (DEB_ON_TICK != 0) ? scan_tick : 1'b1;
   assign any_pressed = |col_stable;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk   (clk),
         .reset (reset),
         .s     (s[g]),
         .se    (se),
         .stable(col_stable[g]),
         .rise  (press_pulse[g]),
         .fall  (release_pulse[g])
      );
   end

endmodule

// File: tb/tb_keypad_col_debouncer.sv
// Scoreboarded bench: a run-length debounce model predicts every output of a
// per-clk instance and a scan-tick-sampled instance, compared each cycle.
module tb_keypad_col_debouncer;

   logic       clk;
   logic       reset;
   logic [3:0] col;
   logic [3:0] col_t;

   logic [3:0] col_stable, press_pulse, release_pulse;
   logic       any_pressed, scan_tick;
   logic [2:0] counter;

   logic [3:0] col_stable_t, press_pulse_t, release_pulse_t;
   logic       any_pressed_t, scan_tick_t;
   logic [2:0] counter_t;

   int vec_count   = 0;
   int miscompares = 0;

   keypad_col_debouncer dut (
      .clk          (clk),
      .reset        (reset),
      .col          (col),
      .col_stable   (col_stable),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .any_pressed  (any_pressed),
      .counter      (counter),
      .scan_tick    (scan_tick)
   );

   keypad_col_debouncer #(.DEB_ON_TICK(1)) dut_tick (
      .clk          (clk),
      .reset        (reset),
      .col          (col_t),
      .col_stable   (col_stable_t),
      .press_pulse  (press_pulse_t),
      .release_pulse(release_pulse_t),
      .any_pressed  (any_pressed_t),
      .counter      (counter_t),
      .scan_tick    (scan_tick_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]      s1;
      logic [3:0]      s2;
      logic [3:0]      stable;
      logic [3:0]      rise;
      logic [3:0]      fall;
      logic [3:0][7:0] run;
   } mdl_t;

   typedef struct packed {
      logic [3:0] stable;
      logic [3:0] press;
      logic [3:0] rel;
      logic [2:0] cnt;
      logic       tick;
      logic [3:0] t_stable;
      logic [3:0] t_press;
      logic [3:0] t_rel;
   } exp_t;

   mdl_t ma = '0;
   mdl_t mb = '0;
   int   mcnt = 0;
   exp_t exp_q[$];

   // A level flips once DEB consecutive samples disagree with it; any agreeing sample restarts the run.
   function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] raw, input logic se);
      mdl_t r = m;
      r.rise = '0;
      r.fall = '0;
      if (se) begin
         for (int i = 0; i < 4; i++) begin
            if (m.s2[i] != m.stable[i]) r.run[i] = m.run[i] + 8'd1;
            else                        r.run[i] = 8'd0;
            if (r.run[i] == 8'd4) begin
               r.stable[i] = ~m.stable[i];
               if (r.stable[i]) r.rise[i] = 1'b1;
               else             r.fall[i] = 1'b1;
               r.run[i] = 8'd0;
            end
         end
      end
      r.s2 = m.s1;
      r.s1 = ~raw;
      return r;
   endfunction

   always @(posedge reset) begin
      ma   = '0;
      mb   = '0;
      mcnt = 0;
   end

   always @(posedge clk) begin
      logic tick_old;
      exp_t e;
      if (reset) begin
         ma   = '0;
         mb   = '0;
         mcnt = 0;
      end else begin
         tick_old = (mcnt == 7);
         ma   = mdl_step(ma, col, 1'b1);
         mb   = mdl_step(mb, col_t, tick_old);
         mcnt = (mcnt + 1) % 8;
      end
      e.stable   = ma.stable;
      e.press    = ma.rise;
      e.rel      = ma.fall;
      e.cnt      = 3'(mcnt);
      e.tick     = (mcnt == 7);
      e.t_stable = mb.stable;
      e.t_press  = mb.rise;
      e.t_rel    = mb.fall;
      exp_q.push_back(e);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vec_count++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("stable",    32'(col_stable),      32'(e.stable));
         checkOutput("press",     32'(press_pulse),     32'(e.press));
         checkOutput("release",   32'(release_pulse),   32'(e.rel));
         checkOutput("any",       32'(any_pressed),     32'(|e.stable));
         checkOutput("counter",   32'(counter),         32'(e.cnt));
         checkOutput("tick",      32'(scan_tick),       32'(e.tick));
         checkOutput("t_stable",  32'(col_stable_t),    32'(e.t_stable));
         checkOutput("t_press",   32'(press_pulse_t),   32'(e.t_press));
         checkOutput("t_release", 32'(release_pulse_t), 32'(e.t_rel));
         checkOutput("t_any",     32'(any_pressed_t),   32'(|e.t_stable));
         checkOutput("t_counter", 32'(counter_t),       32'(e.cnt));
         checkOutput("t_tick",    32'(scan_tick_t),     32'(e.tick));
      end
   end

   task automatic applyStimulus(input logic [3:0] c, input logic [3:0] ct, input int cycles);
      col   = c;
      col_t = ct;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      col   = 4'hF;
      col_t = 4'hF;
      repeat (3) @(negedge clk);
      checkOutput("rst_stable",  32'(col_stable),    32'h0);
      checkOutput("rst_press",   32'(press_pulse),   32'h0);
      checkOutput("rst_release", 32'(release_pulse), 32'h0);
      checkOutput("rst_counter", 32'(counter),       32'h0);
      checkOutput("rst_tick",    32'(scan_tick),     32'h0);
      reset = 1'b0;
      applyStimulus(4'hF, 4'hF, 10);

      $display("[TB] press on col[2]");
      applyStimulus(4'b1011, 4'hF, 5);
      checkOutput("press_early", 32'(col_stable), 32'h0);
      applyStimulus(4'b1011, 4'hF, 1);
      checkOutput("press_stable", 32'(col_stable),  32'h4);
      checkOutput("press_pulse",  32'(press_pulse), 32'h4);
      checkOutput("press_any",    32'(any_pressed), 32'h1);
      applyStimulus(4'b1011, 4'hF, 1);
      checkOutput("press_once",   32'(press_pulse), 32'h0);

      $display("[TB] bounce on col[0]");
      applyStimulus(4'b1010, 4'hF, 3);
      applyStimulus(4'b1011, 4'hF, 1);
      applyStimulus(4'b1010, 4'hF, 12);

      $display("[TB] release col[2], then simultaneous press");
      applyStimulus(4'b1110, 4'hF, 6);
      checkOutput("release_pulse", 32'(release_pulse), 32'h4);
      applyStimulus(4'b1111, 4'hF, 8);
      applyStimulus(4'b0110, 4'hF, 6);
      checkOutput("dual_press", 32'(press_pulse), 32'h9);

      $display("[TB] reset in the middle of a wait");
      applyStimulus(4'b0111, 4'hF, 8);
      applyStimulus(4'b0101, 4'hF, 4);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_stable",  32'(col_stable),  32'h0);
      checkOutput("async_any",     32'(any_pressed), 32'h0);
      checkOutput("async_counter", 32'(counter),     32'h0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(4'b0101, 4'hF, 5);
      checkOutput("post_rst_early", 32'(col_stable), 32'h0);
      applyStimulus(4'b0101, 4'hF, 1);
      checkOutput("post_rst_press", 32'(press_pulse), 32'hA);

      $display("[TB] tick-sampled instance on col[1]");
      applyStimulus(4'b0101, 4'b1101, 12);
      for (int i = 0; i < 8 && mcnt != 2; i++) @(negedge clk);
      applyStimulus(4'b0101, 4'b1111, 3);
      applyStimulus(4'b0101, 4'b1101, 30);
      checkOutput("tick_stable", 32'(col_stable_t), 32'h2);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
